// File: rtl/apb3_wait_slave_if.sv
// APB3 bus bundle for one slave slot.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave  modport: the mirror image
// Parameters: AWIDTH (PADDR width), DWIDTH (data width).
interface apb3_wait_slave_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) ();
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_wait_slave.sv
// APB3 slave memory model with programmable wait states, PSLVERR on
// out-of-range addresses, abort handling and a counting protocol checker.
// Ports:
//   PCLK        bus clock, everything on the rising edge
//   PRESETN     synchronous active-low reset
//   apb         APB3 slave bundle (PSEL, PENABLE, PWRITE, PADDR, PWDATA in;
//               PRDATA registered, PREADY, PSLVERR out)
//   PROT_ERR    sticky: at least one protocol violation seen
//   PROT_ERRCNT saturating (255) protocol violation count
// ID and DEBUG tag diagnostic messages produced by the surrounding
// environment; in this synthesizable model they are only range-checked.
module apb3_wait_slave #(
  parameter int         ID        = 0,
  parameter int         DEBUG     = 0,
  parameter int         AWIDTH    = 8,
  parameter int         DWIDTH    = 32,
  parameter int         DEPTH     = 2**AWIDTH,
  parameter int         WAIT_MODE = 0,
  parameter int         MAX_WAIT  = 0,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  apb3_wait_slave_if.slave apb,
  output logic             PROT_ERR,
  output logic [7:0]       PROT_ERRCNT
);

  localparam int              IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
  localparam logic [3:0]      MAXW    = 4'(MAX_WAIT);

  if (DEPTH < 1 || DEPTH > 2**AWIDTH || MAX_WAIT < 0 || MAX_WAIT > 15 ||
      SEED == 8'h00 || WAIT_MODE < 0 || WAIT_MODE > 1 || DEBUG < 0 || ID < 0) begin : g_bad_param
    $error("apb3_wait_slave slot %0d: illegal parameter combination", ID);
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic [7:0]        lfsr_q;
  logic [AWIDTH-1:0] addr_q;
  logic              write_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              addr_err_q;
  logic [DWIDTH-1:0] prdata_q;
  logic              prot_err_q;
  logic [7:0]        errcnt_q;

  logic [DWIDTH-1:0] ram [DEPTH];

  logic              setup;
  logic              ready;
  logic              complete;
  logic              abort;
  logic              addr_err_d;
  logic [7:0]        lfsr_d;
  logic [3:0]        wait_d;
  logic              viol_d;
  logic [7:0]        errcnt_d;

  assign setup      = apb.PSEL & ~apb.PENABLE;
  assign ready      = (wcnt_q == 4'd0);
  assign complete   = (state_q == ACCESS) & apb.PSEL & apb.PENABLE & ready;
  assign abort      = (state_q == ACCESS) & ~apb.PSEL;
  assign addr_err_d = ({1'b0, apb.PADDR} >= DEPTH_L);

  // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Random mode uses the pre-advance LFSR value, clipped to MAX_WAIT.
  assign wait_d = (WAIT_MODE == 0)      ? MAXW :
                  (lfsr_q[3:0] > MAXW)  ? MAXW : lfsr_q[3:0];

  assign errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;

  // All violation sources collapse into one flag, so at most one count per edge.
  always_comb begin
    viol_d = 1'b0;
    if (state_q == IDLE) begin
      viol_d = apb.PSEL & apb.PENABLE;
    end else begin
      viol_d = abort |
               (apb.PSEL & ((apb.PADDR != addr_q) |
                            (apb.PWRITE != write_q) |
                            (write_q & (apb.PWDATA != wdata_q)) |
                            ~apb.PENABLE));
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= IDLE;
      wcnt_q     <= 4'd0;
      lfsr_q     <= SEED;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
      errcnt_q   <= 8'd0;
    end else begin
      if (viol_d) begin
        prot_err_q <= 1'b1;
        errcnt_q   <= errcnt_d;
      end
      case (state_q)
        IDLE: begin
          if (setup) begin
            addr_q     <= apb.PADDR;
            write_q    <= apb.PWRITE;
            wdata_q    <= apb.PWDATA;
            addr_err_q <= addr_err_d;
            wcnt_q     <= wait_d;
            lfsr_q     <= lfsr_d;
            state_q    <= ACCESS;
            if (!apb.PWRITE) begin
              prdata_q <= addr_err_d ? '0 : ram[apb.PADDR[IDXW-1:0]];
            end
          end
        end
        ACCESS: begin
          if (abort) begin
            // Clearing the counter keeps PREADY high while idle after an abort.
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
          end else if (complete) begin
            state_q <= IDLE;
          end else if (!ready) begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset; a write only lands on an in-range completion.
  always_ff @(posedge PCLK) begin
    if (PRESETN && complete && write_q && !addr_err_q) begin
      ram[addr_q[IDXW-1:0]] <= apb.PWDATA;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = (state_q == ACCESS) & ready & addr_err_q;
  assign PROT_ERR    = prot_err_q;
  assign PROT_ERRCNT = errcnt_q;

endmodule

// File: tb/tb_apb3_wait_slave.sv
// Bench: three slaves share one APB bus, each with its own PSEL.
//   slot 0: fixed 3 waits, DEPTH=16   slot 1: random waits, MAX_WAIT=7
//   slot 2: fixed 0 waits
module tb_apb3_wait_slave;

  logic        clk;
  logic        rstn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata_s  [3];
  logic        pready_s  [3];
  logic        pslverr_s [3];
  logic        perr_s    [3];
  logic [7:0]  pcnt_s    [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    apb3_wait_slave_if #(.AWIDTH(8), .DWIDTH(32)) bus ();
    assign bus.PSEL    = psel[gi];
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PADDR   = paddr;
    assign bus.PWDATA  = pwdata;
    assign prdata_s[gi]  = bus.PRDATA;
    assign pready_s[gi]  = bus.PREADY;
    assign pslverr_s[gi] = bus.PSLVERR;

    apb3_wait_slave #(
      .ID(gi),
      .DEBUG(0),
      .AWIDTH(8),
      .DWIDTH(32),
      .DEPTH((gi == 0) ? 16 : 256),
      .WAIT_MODE((gi == 1) ? 1 : 0),
      .MAX_WAIT((gi == 0) ? 3 : ((gi == 1) ? 7 : 0)),
      .SEED(8'hA5)
    ) u_dut (
      .PCLK(clk),
      .PRESETN(rstn),
      .apb(bus.slave),
      .PROT_ERR(perr_s[gi]),
      .PROT_ERRCNT(pcnt_s[gi])
    );
  end

  // Reference memory and LFSR for the random-wait slot.
  logic [31:0] mem_m [3][256];
  bit          vld_m [3][256];
  int          lfsr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel    = 3'b000;
      penable = 1'b0;
    end
  endtask

  // One full transfer; leaves PSEL high so a following call is back-to-back.
  task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int waits, output int cycles,
                      output bit err, output bit early_err);
    int n;
    @(negedge clk);
    psel    = 3'b000;
    psel[s] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    n       = cyc;
    @(negedge clk);
    penable   = 1'b1;
    waits     = 0;
    early_err = 1'b0;
    while (!pready_s[s] && waits < 40) begin
      early_err |= pslverr_s[s];
      @(negedge clk);
      waits++;
    end
    chk("xfer_bounded", 32'(waits < 40), 32'd1);
    rd  = prdata_s[s];
    err = pslverr_s[s];
    @(posedge clk);
    #1;
    cycles = cyc - n;
  endtask

  logic [31:0] rd, d0, d5, d6, d7, dn;
  int          waits, cycles, w_exp, k;
  bit          err, early;
  logic [7:0]  ra;
  bit          rw;

  initial begin
    rstn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    lfsr_m = 8'hA5;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_prdata", prdata_s[s], 32'd0);
      chk("rst_pready", 32'(pready_s[s]), 32'd1);
      chk("rst_pslverr", 32'(pslverr_s[s]), 32'd0);
      chk("rst_proterr", 32'(perr_s[s]), 32'd0);
      chk("rst_errcnt", 32'(pcnt_s[s]), 32'd0);
    end
    rstn = 1'b1;

    // Zero-wait slot: write then read back-to-back.
    xfer(2, 1'b1, 8'h10, 32'hDEADBEEF, rd, waits, cycles, err, early);
    $display("slot2 wr @10 waits=%0d cycles=%0d", waits, cycles);
    chk("w0_wr_waits", 32'(waits), 32'd0);
    chk("w0_wr_cycles", 32'(cycles), 32'd2);
    xfer(2, 1'b0, 8'h10, 32'h0, rd, waits, cycles, err, early);
    $display("slot2 rd @10 data=%08h waits=%0d cycles=%0d", rd, waits, cycles);
    chk("w0_rd_waits", 32'(waits), 32'd0);
    chk("w0_rd_cycles", 32'(cycles), 32'd2);
    chk("w0_rd_data", rd, 32'hDEADBEEF);
    bus_idle(1);
    chk("w0_errcnt", 32'(pcnt_s[2]), 32'd0);

    // Fixed 3-wait slot: seed a few locations, then read back.
    d0 = $urandom | 32'h1; d5 = $urandom | 32'h1; d6 = $urandom | 32'h1; d7 = $urandom | 32'h1;
    xfer(0, 1'b1, 8'h00, d0, rd, waits, cycles, err, early);
    xfer(0, 1'b1, 8'h06, d6, rd, waits, cycles, err, early);
    xfer(0, 1'b1, 8'h07, d7, rd, waits, cycles, err, early);
    xfer(0, 1'b1, 8'h05, d5, rd, waits, cycles, err, early);
    $display("slot0 wr @05 waits=%0d cycles=%0d", waits, cycles);
    chk("w3_wr_waits", 32'(waits), 32'd3);
    chk("w3_wr_cycles", 32'(cycles), 32'd5);
    chk("w3_wr_slverr", 32'(err), 32'd0);
    xfer(0, 1'b0, 8'h05, 32'h0, rd, waits, cycles, err, early);
    $display("slot0 rd @05 data=%08h waits=%0d cycles=%0d", rd, waits, cycles);
    chk("w3_rd_waits", 32'(waits), 32'd3);
    chk("w3_rd_cycles", 32'(cycles), 32'd5);
    chk("w3_rd_data", rd, d5);

    // Out-of-range on DEPTH=16: 0x20 would alias to entry 0.
    xfer(0, 1'b0, 8'h20, 32'h0, rd, waits, cycles, err, early);
    $display("slot0 rd @20 data=%08h slverr=%0d", rd, err);
    chk("oor_rd_data", rd, 32'd0);
    chk("oor_rd_slverr", 32'(err), 32'd1);
    chk("oor_rd_slverr_early", 32'(early), 32'd0);
    xfer(0, 1'b1, 8'h20, 32'h1234, rd, waits, cycles, err, early);
    $display("slot0 wr @20 slverr=%0d", err);
    chk("oor_wr_slverr", 32'(err), 32'd1);
    chk("oor_wr_slverr_early", 32'(early), 32'd0);
    bus_idle(1);
    chk("oor_slverr_after", 32'(pslverr_s[0]), 32'd0);
    xfer(0, 1'b0, 8'h00, 32'h0, rd, waits, cycles, err, early);
    $display("slot0 rd @00 data=%08h", rd);
    chk("oor_alias_unchanged", rd, d0);
    chk("oor_alias_slverr", 32'(err), 32'd0);
    bus_idle(1);

    // Random-wait slot against the LFSR model.
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom_range(0, 15));
      rw = !vld_m[1][ra] || ($urandom_range(0, 1) == 1);
      dn = $urandom;
      w_exp = ((lfsr_m & 15) > 7) ? 7 : (lfsr_m & 15);
      lfsr_m = lfsr_step(lfsr_m);
      xfer(1, rw, ra, dn, rd, waits, cycles, err, early);
      $display("slot1 #%0d %s @%02h data=%08h waits=%0d", i, rw ? "wr" : "rd", ra, rw ? dn : rd, waits);
      chk("rnd_waits", 32'(waits), 32'(w_exp));
      chk("rnd_waits_le7", 32'(waits <= 7), 32'd1);
      chk("rnd_cycles", 32'(cycles), 32'(w_exp + 2));
      if (rw) begin
        mem_m[1][ra] = dn;
        vld_m[1][ra] = 1'b1;
      end else begin
        chk("rnd_rd_data", rd, mem_m[1][ra]);
      end
      if ($urandom_range(0, 3) == 0) bus_idle(1);
    end
    bus_idle(1);
    chk("rnd_errcnt", 32'(pcnt_s[1]), 32'd0);

    // Violation 1: PADDR changes for one access cycle of a write @3.
    dn = $urandom;
    @(negedge clk); psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = dn;
    @(negedge clk); penable = 1'b1; paddr = 8'h04;
    @(negedge clk); paddr = 8'h03;
    k = 0;
    while (!pready_s[0] && k < 40) begin @(negedge clk); k++; end
    chk("viol1_bounded", 32'(k < 40), 32'd1);
    @(posedge clk); #1;
    bus_idle(1);
    $display("viol1 paddr change errcnt=%0d", pcnt_s[0]);
    chk("viol1_errcnt", 32'(pcnt_s[0]), 32'd1);
    chk("viol1_proterr", 32'(perr_s[0]), 32'd1);
    xfer(0, 1'b0, 8'h03, 32'h0, rd, waits, cycles, err, early);
    chk("viol1_wr_landed", rd, dn);
    bus_idle(1);

    // Violation 2: PENABLE without a setup phase.
    @(negedge clk); psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 8'h05;
    @(negedge clk); psel = 3'b000; penable = 1'b0;
    $display("viol2 no setup errcnt=%0d", pcnt_s[0]);
    chk("viol2_errcnt", 32'(pcnt_s[0]), 32'd2);

    // Violation 3: PSEL dropped during the wait of a write @6.
    dn = ~d6;
    @(negedge clk); psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h06; pwdata = dn;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    $display("viol3 abort errcnt=%0d proterr=%0d", pcnt_s[0], perr_s[0]);
    chk("viol3_errcnt", 32'(pcnt_s[0]), 32'd3);
    chk("viol3_proterr", 32'(perr_s[0]), 32'd1);
    xfer(0, 1'b0, 8'h06, 32'h0, rd, waits, cycles, err, early);
    $display("slot0 rd @06 after abort data=%08h cycles=%0d", rd, cycles);
    chk("viol3_no_write", rd, d6);
    chk("viol3_idle_cycles", 32'(cycles), 32'd5);
    bus_idle(1);
    chk("viol3_errcnt_final", 32'(pcnt_s[0]), 32'd3);

    // One-cycle reset during the wait of a write @7.
    dn = ~d7;
    @(negedge clk); psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = dn;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1; psel = 3'b000; penable = 1'b0;
    $display("midreset prdata=%08h pready=%0d errcnt=%0d", prdata_s[0], pready_s[0], pcnt_s[0]);
    chk("mrst_prdata", prdata_s[0], 32'd0);
    chk("mrst_pready", 32'(pready_s[0]), 32'd1);
    chk("mrst_pslverr", 32'(pslverr_s[0]), 32'd0);
    chk("mrst_proterr", 32'(perr_s[0]), 32'd0);
    chk("mrst_errcnt", 32'(pcnt_s[0]), 32'd0);
    xfer(0, 1'b0, 8'h07, 32'h0, rd, waits, cycles, err, early);
    $display("slot0 rd @07 after reset data=%08h cycles=%0d", rd, cycles);
    chk("mrst_no_write", rd, d7);
    chk("mrst_next_cycles", 32'(cycles), 32'd5);
    chk("mrst_next_slverr", 32'(err), 32'd0);
    bus_idle(1);
    chk("mrst_errcnt_after", 32'(pcnt_s[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
